ps2_teclado: RTL and testbench

PS/2 keyboard receiver that produces the 32-bit teclado word read by the CPU when the address decoder selects the keyboard chip (selectChips = 2'b10). It replaces the constant keyboard value currently tied into the top level. It deserialises PS/2 frames and decodes make, break (F0) and extended (E0) sequences. It holds the current key code, a key-held flag, a new-key flag and a sticky error flag in a memory-mapped status word.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sincronizador.sv | 28 ++
 rtl/ps2_teclado.sv | 151 +++++++++++++++
 tb/tb_ps2_teclado.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic {IDLE = 1'b0, RECIBIR = 1'b1} estado_t;

  localparam logic [7:0] PREF_RELEASE = 8'hF0;
  localparam logic [7:0] PREF_EXT     = 8'hE0;

  // Field positions inside the teclado status word
  localparam int BIT_EXT   = 8;
  localparam int BIT_PRES  = 9;
  localparam int BIT_NUEVA = 10;
  localparam int BIT_ERR   = 16;

  localparam int TIMEOUT_DEF = 100000;
  localparam int TO_W        = $clog2(TIMEOUT_DEF);

  // Counter width able to hold TIMEOUT-1
  function automatic int to_width(input int t);
    return (t < 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/ps2_sincronizador.sv
// Two-flop synchroniser for one PS/2 line plus a 1->0 edge strobe.
module ps2_sincronizador (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic caida
);

  logic ff1, ff2, prev;

  // Idle PS/2 lines are high; resetting to 1 avoids a false edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1  <= 1'b1;
      ff2  <= 1'b1;
      prev <= 1'b1;
    end else begin
      ff1  <= d;
      ff2  <= ff1;
      prev <= ff2;
    end
  end

  assign q     = ff2;
  assign caida = prev & ~ff2;

endmodule

// File: rtl/ps2_teclado.sv
// PS/2 keyboard receiver: frame deserialiser, make/break/extended decoder
// and memory-mapped status word for the CPU.
module ps2_teclado
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2Clk,
  input  logic        ps2Dat,
  input  logic        leer,
  output logic [31:0] teclado,
  output logic        nuevaTecla
);

  localparam int CW = to_width(TIMEOUT);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT - 1);

  logic [1:0] pins_raw, pins_s, caidas;
  logic       caida, dat;
  logic       unused_sinc;

  assign pins_raw = {ps2Dat, ps2Clk};

  for (genvar g = 0; g < 2; g++) begin : g_sinc
    ps2_sincronizador u_sinc (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pins_raw[g]),
      .q     (pins_s[g]),
      .caida (caidas[g])
    );
  end

  assign caida       = caidas[0];
  assign dat         = pins_s[1];
  assign unused_sinc = pins_s[0] ^ caidas[1];

  estado_t       estado, estado_nx;
  logic [3:0]    bit_cnt;
  logic [8:0]    sr;
  logic [CW-1:0] to_cnt;
  logic          fin_trama, timeout_evt, byte_valido, trama_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_nx;
  end

  always_comb begin
    estado_nx   = estado;
    fin_trama   = 1'b0;
    timeout_evt = 1'b0;
    case (estado)
      IDLE:
        if (caida && !dat) estado_nx = RECIBIR;
      RECIBIR:
        if (caida) begin
          if (bit_cnt == 4'd9) begin
            estado_nx = IDLE;
            fin_trama = 1'b1;
          end
        end else if (to_cnt == TO_MAX) begin
          estado_nx   = IDLE;
          timeout_evt = 1'b1;
        end
      default: estado_nx = IDLE;
    endcase
  end

  // In the stop-bit cycle dat is the stop bit and sr holds {parity, data}
  assign byte_valido = fin_trama & dat & (^sr);
  assign trama_err   = fin_trama & ~(dat & (^sr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sr      <= '0;
      to_cnt  <= '0;
    end else begin
      if (estado == IDLE || fin_trama || timeout_evt) bit_cnt <= '0;
      else if (caida)                                 bit_cnt <= bit_cnt + 4'd1;

      if (estado == RECIBIR && caida && bit_cnt < 4'd9) sr <= {dat, sr[8:1]};

      if (estado == IDLE || caida || timeout_evt) to_cnt <= '0;
      else                                        to_cnt <= to_cnt + 1'b1;
    end
  end

  logic [7:0] rx_byte, codigo;
  logic       extendido, presionada, nueva, error, ext, rel;
  logic       es_ext, es_rel, make, suelta, err_set;

  assign rx_byte = sr[7:0];
  assign es_ext  = byte_valido && rx_byte == PREF_EXT;
  assign es_rel  = byte_valido && rx_byte == PREF_RELEASE;
  assign make    = byte_valido && !es_ext && !es_rel && !rel;
  assign suelta  = byte_valido && !es_ext && !es_rel && rel;
  assign err_set = trama_err | timeout_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codigo     <= '0;
      extendido  <= 1'b0;
      presionada <= 1'b0;
      nueva      <= 1'b0;
      error      <= 1'b0;
      ext        <= 1'b0;
      rel        <= 1'b0;
      nuevaTecla <= 1'b0;
    end else begin
      nuevaTecla <= make;
      if (es_ext) ext <= 1'b1;
      if (es_rel) rel <= 1'b1;
      if (make) begin
        codigo     <= rx_byte;
        extendido  <= ext;
        presionada <= 1'b1;
        ext        <= 1'b0;
      end
      // A break for a key other than the one held is ignored
      if (suelta) begin
        if (rx_byte == codigo && ext == extendido) begin
          codigo     <= '0;
          extendido  <= 1'b0;
          presionada <= 1'b0;
        end
        rel <= 1'b0;
        ext <= 1'b0;
      end
      if (leer) begin
        nueva <= 1'b0;
        error <= 1'b0;
      end
      if (make)    nueva <= 1'b1;
      if (err_set) error <= 1'b1;
    end
  end

  always_comb begin
    teclado            = '0;
    teclado[7:0]       = codigo;
    teclado[BIT_EXT]   = extendido;
    teclado[BIT_PRES]  = presionada;
    teclado[BIT_NUEVA] = nueva;
    teclado[BIT_ERR]   = error;
  end

endmodule

// File: tb/tb_ps2_teclado.sv
// Directed bench for ps2_teclado: bit-banged PS/2 frames, hand-computed status words.
module tb_ps2_teclado;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2Clk = 1'b1;
  logic        ps2Dat = 1'b1;
  logic        leer = 1'b0;
  logic [31:0] teclado;
  logic        nuevaTecla;

  int total = 0;
  int bad   = 0;
  int pulses, first;

  ps2_teclado #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2Clk     (ps2Clk),
    .ps2Dat     (ps2Dat),
    .leer       (leer),
    .teclado    (teclado),
    .nuevaTecla (nuevaTecla)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // nbits < 11 sends a truncated frame; leer_at pulses leer at that clk of the stop bit
  task automatic send(input logic [7:0] b, input logic bad_par, input int nbits,
                      input int leer_at, output int np, output int fk);
    logic [10:0] bits;
    bits = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    np = 0;
    fk = 0;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2Dat = bits[i];
      repeat (3) @(posedge clk);
      #1 ps2Clk = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk); #1;
        leer = (i == 10 && k == leer_at);
        if (nuevaTecla) begin
          np++;
          if (fk == 0) fk = k;
        end
      end
      leer = 1'b0;
      ps2Clk = 1'b1;
      repeat (3) @(posedge clk);
    end
    #1 ps2Dat = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b);
    send(b, 1'b0, 11, 0, pulses, first);
  endtask

  task automatic do_leer();
    @(posedge clk); #1 leer = 1'b1;
    @(posedge clk); #1 leer = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    chk("reset_teclado", teclado, 32'h0);
    chk("reset_pulse", {31'b0, nuevaTecla}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: make 0x1C
    frame(8'h1C);
    chk("make_1c", teclado, 32'h0000061C);
    chk("make_pulses", pulses, 1);
    chk("make_latency", (first >= 1 && first <= 4) ? 32'd1 : 32'd0, 32'd1);
    do_leer();
    chk("leer_1c", teclado, 32'h0000021C);

    // 2: break handling
    frame(8'hF0);
    chk("f0_no_pulse", pulses, 0);
    frame(8'h1C);
    do_leer();
    chk("break_1c", teclado, 32'h0);
    frame(8'h1C);
    do_leer();
    frame(8'hF0);
    frame(8'h23);
    chk("break_other", teclado, 32'h0000021C);
    frame(8'hF0);
    frame(8'h1C);
    chk("break_1c_b", teclado, 32'h0);

    // 3: extended keys
    frame(8'hE0);
    frame(8'h75);
    chk("ext_make", teclado, 32'h00000775);
    do_leer();
    chk("ext_leer", teclado, 32'h00000375);
    frame(8'hE0);
    frame(8'hF0);
    frame(8'h75);
    chk("ext_break_pulse", pulses, 0);
    do_leer();
    chk("ext_break", teclado, 32'h0);

    // 4: parity error
    frame(8'h1C);
    do_leer();
    send(8'h1C, 1'b1, 11, 0, pulses, first);
    chk("par_err", teclado, 32'h0001021C);
    chk("par_no_pulse", pulses, 0);
    frame(8'h29);
    chk("after_err", teclado, 32'h00010629);
    do_leer();
    chk("err_cleared", teclado, 32'h00000229);

    // 5: timeout
    send(8'h55, 1'b0, 5, 0, pulses, first);
    chk("pre_timeout", teclado, 32'h00000229);
    repeat (TO + 20) @(posedge clk);
    #1;
    chk("timeout_err", teclado, 32'h00010229);
    frame(8'h29);
    chk("post_timeout", teclado, 32'h00010629);
    do_leer();

    // 6: reset mid-frame discards partial frame and pending F0
    frame(8'hF0);
    send(8'h55, 1'b0, 5, 0, pulses, first);
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    chk("async_reset", teclado, 32'h0);
    chk("async_reset_pulse", {31'b0, nuevaTecla}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    frame(8'h1C);
    chk("after_reset", teclado, 32'h0000061C);
    do_leer();
    chk("after_reset_leer", teclado, 32'h0000021C);
    send(8'h1C, 1'b0, 11, 2, pulses, first);
    chk("leer_vs_make", teclado, 32'h0000061C);
    chk("leer_vs_make_pulse", pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
